mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 64: maximum cycles a granted access waits for mem_done before it is aborted (legal range 2..255).
REQ-002 The block SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port i_rd  in  1  instruction-fetch read request, held by requester until i_done.
REQ-005 The block SHALL have port i_addr  in  16  instruction-fetch address.
REQ-006 The block SHALL have ports d_rd, d_wr  in  1 each  data read/write request, held until d_done; both high is illegal and treated as write.
REQ-007 The block SHALL have ports d_addr, d_wdata  in  16 each  data address and write data.
REQ-008 The block SHALL have ports i_rdata, d_rdata  out  16 each  read data, valid only in the done cycle.
REQ-009 The block SHALL have ports i_done, d_done, i_stall, d_stall, i_err, d_err  out  1 each  per-requester completion, stall and error.
REQ-010 The block SHALL have ports mem_addr, mem_wdata  out  16  and mem_rd, mem_wr  out  1  driving the shared memory system.
REQ-011 The block SHALL have ports mem_rdata  in  16  and mem_done, mem_stall, mem_err  in  1  returned by the memory system.

Function
REQ-012 The FSM SHALL have states IDLE, BUSY_I, BUSY_D.
REQ-013 In IDLE with any request pending, the block SHALL grant one requester and move to BUSY_I or BUSY_D on the next edge.
REQ-014 Grant SHALL be round-robin: with both pending, the requester not granted last wins; the last-grant flag resets to I, so D wins the first tie.
REQ-015 At grant the block SHALL register addr, wdata and operation (rd/wr) of the winner; requester input changes during BUSY SHALL be ignored.
REQ-016 In BUSY_x the block SHALL drive mem_addr/mem_wdata from the registers and hold mem_rd or mem_wr high every cycle until mem_done or abort.
REQ-017 In IDLE, mem_rd and mem_wr SHALL be 0, and mem_addr and mem_wdata SHALL be 0.
REQ-018 On mem_done in BUSY_x, x_done SHALL be 1 for that same cycle with x_rdata = mem_rdata (combinational pass-through), and the FSM SHALL return to IDLE.
REQ-019 The non-owner's rdata SHALL be 0; the owner's rdata SHALL be 0 outside its done cycle.
REQ-020 x_stall SHALL be 1 whenever x has a request asserted and x_done is 0 in that cycle (including while waiting for grant).
REQ-021 A 8-bit wait counter SHALL clear at grant and increment each BUSY cycle without mem_done.
REQ-022 If the counter reaches TIMEOUT-1 without mem_done, the block SHALL assert x_err and x_done for one cycle, drop mem_rd/mem_wr, and return to IDLE.
REQ-023 mem_err during BUSY_x SHALL be forwarded as x_err in that cycle; if coincident with mem_done, both are reported together.
REQ-024 mem_done in IDLE SHALL be ignored (no done or err to either requester).
REQ-025 The block SHALL NOT issue a new grant in the same cycle as a done; minimum spacing between grants is 2 cycles (done cycle, then IDLE grant cycle).
REQ-026 mem_stall SHALL NOT affect FSM transitions; completion is signalled only by mem_done.
REQ-027 A requester dropping its request mid-BUSY SHALL NOT abort the access; the completion is still generated.

Reset
REQ-028 While rst is high, the FSM SHALL be IDLE, the last-grant flag I, the counter and all address/data/op registers 0.
REQ-029 While rst is high, all outputs SHALL be 0, including stall outputs regardless of request inputs.
REQ-030 Reset asserted mid-access SHALL abort immediately with no done or err issued; the first grant after release follows REQ-014.

Verification
REQ-031 I-only read: i_rd=1, i_addr=0x0100; mem_done after 3 BUSY cycles with mem_rdata=0xBEEF -> i_done=1 with i_rdata=0xBEEF in that cycle; i_stall=1 in every prior cycle.
REQ-032 Simultaneous first requests: i_rd and d_wr (d_addr=0x0200, d_wdata=0x1234) in the same cycle after reset -> D is granted first with mem_wr=1, mem_addr=0x0200, mem_wdata=0x1234; I is granted 2 cycles after d_done.
REQ-033 Fairness: both requesters held continuously for 6 accesses -> grants alternate D,I,D,I,D,I.
REQ-034 Timeout: TIMEOUT=8 with mem_done never asserted -> d_err=1 and d_done=1 in the 8th BUSY cycle; mem_wr=0 in the next cycle.
REQ-035 Error pass-through: mem_err=1 and mem_done=1 together in BUSY_I -> i_err=1 and i_done=1 in the same cycle, with d_err=0.
REQ-036 Reset mid-access: rst pulsed in BUSY_D -> all outputs 0 at once, no d_done; a pending i_rd after release is granted.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / data) arbiter for a single shared memory port.
// Round-robin grant, one outstanding access, per-access wait-counter timeout.
module mem_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rd,
    input  logic [15:0] i_addr,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] i_rdata,
    output logic [15:0] d_rdata,
    output logic        i_done,
    output logic        d_done,
    output logic        i_stall,
    output logic        d_stall,
    output logic        i_err,
    output logic        d_err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    input  logic        mem_stall,
    input  logic        mem_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        last_d_q, last_d_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;

    logic i_req, d_req, grant_d, busy, timeout, finish, own_i, own_d;

    always_comb begin
        i_req   = i_rd;
        d_req   = d_rd | d_wr;
        // On a tie the requester that did not win last time gets the port.
        grant_d = d_req & (~i_req | ~last_d_q);
        busy    = (state_q != IDLE);
        own_i   = (state_q == BUSY_I);
        own_d   = (state_q == BUSY_D);
        timeout = busy & ~mem_done & (cnt_q == TMO_LAST);
        finish  = busy & (mem_done | timeout);
    end

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wr_d     = wr_q;
        case (state_q)
            IDLE: begin
                if (i_req | d_req) begin
                    cnt_d = 8'd0;
                    if (grant_d) begin
                        state_d  = BUSY_D;
                        last_d_d = 1'b1;
                        addr_d   = d_addr;
                        wdata_d  = d_wdata;
                        wr_d     = d_wr;
                    end else begin
                        state_d  = BUSY_I;
                        last_d_d = 1'b0;
                        addr_d   = i_addr;
                        wdata_d  = 16'd0;
                        wr_d     = 1'b0;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                // Done cycle always returns to IDLE, so a new grant is at least two cycles away.
                if (finish) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            cnt_q    <= 8'd0;
            addr_q   <= 16'd0;
            wdata_q  <= 16'd0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wr_q     <= wr_d;
        end
    end

    // Outputs are forced low during reset; stall would otherwise follow the raw requests.
    always_comb begin
        i_rdata   = 16'd0;
        d_rdata   = 16'd0;
        i_done    = 1'b0;
        d_done    = 1'b0;
        i_stall   = 1'b0;
        d_stall   = 1'b0;
        i_err     = 1'b0;
        d_err     = 1'b0;
        mem_addr  = 16'd0;
        mem_wdata = 16'd0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        if (!rst) begin
            mem_rd    = busy & ~wr_q;
            mem_wr    = busy & wr_q;
            mem_addr  = busy ? addr_q : 16'd0;
            mem_wdata = busy ? wdata_q : 16'd0;
            i_done    = own_i & finish;
            d_done    = own_d & finish;
            i_err     = own_i & (mem_err | timeout);
            d_err     = own_d & (mem_err | timeout);
            i_rdata   = (own_i & mem_done) ? mem_rdata : 16'd0;
            d_rdata   = (own_d & mem_done) ? mem_rdata : 16'd0;
            i_stall   = i_rd & ~i_done;
            d_stall   = (d_rd | d_wr) & ~d_done;
        end
    end

    logic unused_mem_stall;
    assign unused_mem_stall = mem_stall;

endmodule
